conv_pe_q: RTL and testbench
============================

# conv_pe_q

Parametrised successor to the fixed 8-channel 3×3 convolution PE.

- Multiplies a 3×3×PAR_CH window of unsigned pixels by signed weights and accumulates over channel-group beats.
- Supports a per-beat 1×1 / 3×3 mode and full-pipeline valid/ready backpressure.
- Adds bias, then requantises (rounding right shift, optional leaky activation, saturation) to OUT_W bits.
- Sits between the line-buffer/window generator and the output-feature-map writer.

## Interface
- PAR_CH, 8, input channels consumed per beat
- PIX_W, 8, unsigned pixel width
- WGT_W, 8, signed weight width
- ACC_W, 32, accumulator / bias / raw-output width
- SHIFT_W, 5, requant shift width
- OUT_W, 8, signed quantised output width

- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- last_channel  in  1  final beat of output pixel
- mode_1x1  in  1  1: centre tap only; 0: full 3×3
- pixels  in  [0:2][0:2][PAR_CH*PIX_W]  window; channel j at [j*PIX_W +: PIX_W]
- weights  in  9*PAR_CH*WGT_W  tap i (row-major), channel j at [(i*PAR_CH+j)*WGT_W +: WGT_W]
- bias  in  ACC_W  signed, sampled on last_channel beat
- shift  in  SHIFT_W  requant shift, sampled on last_channel beat
- act_en  in  1  enable activation, sampled on last_channel beat
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_raw  out  ACC_W  signed acc + bias
- out_q  out  OUT_W  signed requantised result

## Operation
- Pipeline advance: adv = !out_valid || out_ready. All stages, including the DSP data path, are clock-enabled by adv. in_ready = adv.
- S1 products: p[i][j] = {0,pixel} × weight, signed PIX_W+WGT_W+1 bits. If mode_1x1, products for taps ≠ 4 are forced to 0.
- S2 spatial sums: per tap, width grows by clog2(PAR_CH).
- S3 cycle sum over the 9 taps: width grows by 4 more bits, sign-extended to ACC_W.
- S4 accumulate:
  - Non-last beat: acc += cycle_sum.
  - Last beat: out_raw = acc + cycle_sum + bias, then acc ← 0.
  - All ACC_W arithmetic wraps in two's complement; there is no saturation.
- S5 requantise:
  - y = shift==0 ? raw : (raw + 2^(shift−1)) >>> shift.
  - If activation is compiled in and act_en is set, apply it to y.
  - Saturate to [−2^(OUT_W−1), 2^(OUT_W−1)−1], register into out_q, and set out_valid.
- Sideband signals travel with their beat: valid, last, mode, bias, shift, act_en.
- Mode may change between beats of one group; each beat uses its own mode.
- Data-path registers (products, sums) have no reset, to allow DSP inference. Control registers, acc and outputs do reset.

## Timing
- Reset values: in_ready 1 after reset (while rst is high, in_ready is 0); out_valid 0; out_raw 0; out_q 0; acc 0; all valid pipe bits 0.
- Latency: result appears 5 cycles after the accepting edge of the last_channel beat, with out_ready held high.
- Throughput: 1 beat per cycle.
- out_valid && !out_ready: out_raw and out_q hold stable, in_ready = 0, the whole pipeline freezes, and no beat is lost or duplicated.
- A beat presented with in_ready = 0 is not consumed. The source holds it until it is accepted.
- Reset mid-group: the partial accumulation and all in-flight beats are discarded. The next accepted beat starts a new group.
- A single-beat group (last_channel on the first beat) is legal and yields cycle_sum + bias.

## Configuration
- CONV_PE_LEAKY_EN defined: when act_en = 1 and y < 0, y ← (y × 13) >>> 7 (≈0.1, floor), applied before saturation.
- CONV_PE_LEAKY_EN undefined: no activation logic; act_en is ignored, and the stage applies rounding shift and saturation only.

## Structure
- Package conv_pkg holds:
  - the localparams derived from the parameters: PROD_W, SPAT_W, CYC_W;
  - the tap count of 9 and the centre-tap index of 4;
  - the function sat_s(val, OUT_W).
- Sub-module conv_pe_requant implements S5: rounding shift, optional leaky, saturation.

## Test plan
1. Defaults, 3×3 mode, all pixels 1, all weights 1, one last_channel beat, bias 0, shift 0 → out_raw 72, out_q 72, 5 cycles after acceptance.
2. Same data, two beats (second marks last), shift 1 → out_raw 144, out_q 72. A following third beat starts from acc 0.
3. mode_1x1, pixels 1, weights 1, bias 10, last beat → out_raw 18, out_q 18.
4. Pixels 255, weights −1, 3×3 mode, shift 4, act_en 1 → out_raw −18360. out_q is −117 with CONV_PE_LEAKY_EN and −128 without it.
5. Back-to-back groups with out_ready low for 3 cycles while out_valid is high → in_ready low for those cycles, outputs stable, every group's result delivered once and in order.
6. rst pulsed after 1 of 2 beats → no output. A fresh single-beat group of test 1 yields 72.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared widths, tap constants and helpers for the conv PE.
// Default-parameter widths are exported; width functions serve other configs.
package conv_pkg;

  localparam int PAR_CH_D = 8;
  localparam int PIX_W_D  = 8;
  localparam int WGT_W_D  = 8;

  localparam int N_TAPS  = 9;
  localparam int CTR_TAP = 4;

  localparam int PROD_W = PIX_W_D + WGT_W_D + 1;
  localparam int SPAT_W = PROD_W + $clog2(PAR_CH_D);
  localparam int CYC_W  = SPAT_W + 4;

  function automatic int prod_w(input int pw, input int ww);
    return pw + ww + 1;
  endfunction

  function automatic int spat_w(input int pw, input int ww,
                                input int ch);
    return prod_w(pw, ww) + $clog2(ch);
  endfunction

  function automatic int cyc_w(input int pw, input int ww,
                               input int ch);
    return spat_w(pw, ww, ch) + 4;
  endfunction

  // Clamp to the signed range of an ow-bit result.
  function automatic logic signed [63:0] sat_s(
    input logic signed [63:0] val,
    input int                 ow
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (val > hi) return hi;
    if (val < lo) return lo;
    return val;
  endfunction

endpackage

// File: rtl/conv_pe_requant.sv
// conv_pe_requant: rounding right shift, optional leaky, saturation.
// Leaky slope (x*13>>>7) is present only with CONV_PE_LEAKY_EN.
module conv_pe_requant
  import conv_pkg::*;
#(
  parameter int ACC_W   = 32,
  parameter int SHIFT_W = 5,
  parameter int OUT_W   = 8
) (
  input  logic signed [ACC_W-1:0]   i_raw,
  input  logic        [SHIFT_W-1:0] i_shift,
  input  logic                      i_act_en,
  output logic signed [OUT_W-1:0]   o_q
);

  localparam int RW = ACC_W + 1;
  localparam int XW = 64;

  logic signed [RW-1:0] w_rnd;
  logic signed [RW-1:0] w_sum;
  logic signed [RW-1:0] w_y;
  logic signed [XW-1:0] w_yx;
  logic signed [XW-1:0] w_act;

  // One extra bit keeps the rounding add exact near full scale.
  always_comb begin
    w_rnd = '0;
    if (i_shift != '0)
      w_rnd = RW'(1) << (i_shift - SHIFT_W'(1));
    w_sum = {i_raw[ACC_W-1], i_raw} + w_rnd;
    w_y   = w_sum >>> i_shift;
    w_yx  = {{(XW-RW){w_y[RW-1]}}, w_y};
  end

`ifdef CONV_PE_LEAKY_EN
  always_comb begin
    w_act = w_yx;
    if (i_act_en && w_yx < 0)
      w_act = (w_yx * 64'sd13) >>> 7;
  end
`else
  logic w_unused_act;
  assign w_unused_act = i_act_en;
  assign w_act        = w_yx;
`endif

  assign o_q = OUT_W'(sat_s(w_act, OUT_W));

endmodule

// File: rtl/conv_pe_q.sv
// conv_pe_q: 3x3xPAR_CH conv PE, beat accumulate, bias, requantise.
// Optional leaky activation: define CONV_PE_LEAKY_EN.
module conv_pe_q
  import conv_pkg::*;
#(
  parameter int PAR_CH  = 8,
  parameter int PIX_W   = 8,
  parameter int WGT_W   = 8,
  parameter int ACC_W   = 32,
  parameter int SHIFT_W = 5,
  parameter int OUT_W   = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               last_channel,
  input  logic                               mode_1x1,
  input  logic [0:2][0:2][PAR_CH*PIX_W-1:0]  pixels,
  input  logic [N_TAPS*PAR_CH*WGT_W-1:0]     weights,
  input  logic signed [ACC_W-1:0]            bias,
  input  logic [SHIFT_W-1:0]                 shift,
  input  logic                               act_en,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic signed [ACC_W-1:0]            out_raw,
  output logic signed [OUT_W-1:0]            out_q
);

  localparam int P_W = prod_w(PIX_W, WGT_W);
  localparam int S_W = spat_w(PIX_W, WGT_W, PAR_CH);
  localparam int C_W = cyc_w(PIX_W, WGT_W, PAR_CH);

  logic                              w_adv;
  logic [4:0]                        r_v;
  logic [3:0]                        r_last;
  logic                              r_mode0;
  logic [0:2][0:2][PAR_CH*PIX_W-1:0] r_pix0;
  logic [N_TAPS*PAR_CH*WGT_W-1:0]    r_wgt0;
  logic [3:0][ACC_W-1:0]             r_bias;
  logic [4:0][SHIFT_W-1:0]           r_sh;
  logic [4:0]                        r_act;

  logic signed [P_W-1:0] w_prod [N_TAPS][PAR_CH];
  logic signed [P_W-1:0] r_prod [N_TAPS][PAR_CH];
  logic signed [S_W-1:0] w_spat [N_TAPS];
  logic signed [S_W-1:0] r_spat [N_TAPS];
  logic signed [C_W-1:0] w_cyc;
  logic signed [C_W-1:0] r_cyc;

  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_raw;
  logic signed [OUT_W-1:0] w_q;

  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv && !rst;

  function automatic logic signed [P_W-1:0] mul(
    input logic        [PIX_W-1:0] p,
    input logic signed [WGT_W-1:0] w
  );
    logic signed [P_W-1:0] a;
    logic signed [P_W-1:0] b;
    a = $signed({{(P_W-PIX_W){1'b0}}, p});
    b = {{(P_W-WGT_W){w[WGT_W-1]}}, w};
    return a * b;
  endfunction

  // Pixels are unsigned: zero-extend before the signed multiply.
  for (genvar i = 0; i < N_TAPS; i++) begin : g_tap
    for (genvar j = 0; j < PAR_CH; j++) begin : g_ch
      assign w_prod[i][j] =
        (r_mode0 && i != CTR_TAP) ? '0 :
        mul(r_pix0[i/3][i%3][j*PIX_W +: PIX_W],
            r_wgt0[(i*PAR_CH+j)*WGT_W +: WGT_W]);
    end
  end

  always_comb begin
    for (int i = 0; i < N_TAPS; i++) begin
      w_spat[i] = '0;
      for (int j = 0; j < PAR_CH; j++)
        w_spat[i] = w_spat[i] + S_W'(r_prod[i][j]);
    end
  end

  always_comb begin
    w_cyc = '0;
    for (int i = 0; i < N_TAPS; i++)
      w_cyc = w_cyc + C_W'(r_spat[i]);
  end

  assign w_sum = r_acc + ACC_W'(r_cyc);

  // Data path: no reset so the tools can pack it into DSP slices.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_pix0  <= pixels;
      r_wgt0  <= weights;
      r_mode0 <= mode_1x1;
      r_prod  <= w_prod;
      r_spat  <= w_spat;
      r_cyc   <= w_cyc;
      r_bias  <= {r_bias[2:0], bias};
      r_sh    <= {r_sh[3:0], shift};
      r_act   <= {r_act[3:0], act_en};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v       <= '0;
      r_last    <= '0;
      r_acc     <= '0;
      r_raw     <= '0;
      out_valid <= 1'b0;
      out_raw   <= '0;
      out_q     <= '0;
    end else if (w_adv) begin
      r_v    <= {r_v[3] && r_last[3], r_v[2:0], in_valid};
      r_last <= {r_last[2:0], last_channel};
      if (r_v[3]) begin
        if (r_last[3]) begin
          r_raw <= w_sum + $signed(r_bias[3]);
          r_acc <= '0;
        end else begin
          r_acc <= w_sum;
        end
      end
      out_valid <= r_v[4];
      if (r_v[4]) begin
        out_raw <= r_raw;
        out_q   <= w_q;
      end
    end
  end

  conv_pe_requant #(
    .ACC_W   (ACC_W),
    .SHIFT_W (SHIFT_W),
    .OUT_W   (OUT_W)
  ) u_requant (
    .i_raw    (r_raw),
    .i_shift  (r_sh[4]),
    .i_act_en (r_act[4]),
    .o_q      (w_q)
  );

endmodule

// File: tb/tb_conv_pe_q.sv
// tb_conv_pe_q: scoreboard bench with a plain-arithmetic reference model.
// Honours CONV_PE_LEAKY_EN the same way the design does.
module tb_conv_pe_q;

  typedef logic [0:2][0:2][63:0] pix_t;
  typedef logic [575:0]          wgt_t;

  typedef struct {
    longint raw;
    longint q;
    int     cyc;
    bit     lat;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic               last_channel;
  logic               mode_1x1;
  pix_t               pixels;
  wgt_t               weights;
  logic signed [31:0] bias;
  logic [4:0]         shift;
  logic               act_en;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_raw;
  logic signed [7:0]  out_q;

  int     n_chk   = 0;
  int     n_fail  = 0;
  int     n_stall = 0;
  int     cyc     = 0;
  longint m_acc   = 0;
  bit     rdy_rand  = 0;
  bit     rdy_force = 1;
  exp_t   sbq[$];

  conv_pe_q dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .last_channel (last_channel),
    .mode_1x1     (mode_1x1),
    .pixels       (pixels),
    .weights      (weights),
    .bias         (bias),
    .shift        (shift),
    .act_en       (act_en),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_raw      (out_raw),
    .out_q        (out_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  task automatic chk(input string name, input longint act,
                     input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic longint wrap32(input longint v);
    logic signed [31:0] t;
    t = v[31:0];
    return t;
  endfunction

  function automatic longint cyc_sum(input pix_t px, input wgt_t wt,
                                     input bit mode);
    longint s;
    logic [7:0] p;
    logic signed [7:0] w;
    s = 0;
    for (int t = 0; t < 9; t++) begin
      if (!(mode && t != 4)) begin
        for (int j = 0; j < 8; j++) begin
          p = px[t/3][t%3][j*8 +: 8];
          w = wt[(t*8+j)*8 +: 8];
          s += longint'(p) * longint'(w);
        end
      end
    end
    return s;
  endfunction

  function automatic longint model_q(input longint raw, input int sh,
                                     input bit act);
    longint y;
    y = raw;
    if (sh != 0) y = (raw + (longint'(1) << (sh - 1))) >>> sh;
`ifdef CONV_PE_LEAKY_EN
    if (act && y < 0) y = (y * 13) >>> 7;
`else
    if (act) y = y + 0;
`endif
    if (y > 127)  y = 127;
    if (y < -128) y = -128;
    return y;
  endfunction

  task automatic send(input pix_t px, input wgt_t wt, input bit last,
                      input bit mode, input logic signed [31:0] b,
                      input logic [4:0] sh, input bit act,
                      input bit use_exp, input longint er,
                      input longint eq, input bit lat);
    bit     ok;
    longint raw;
    exp_t   e;
    pixels = px; weights = wt; last_channel = last;
    mode_1x1 = mode; bias = b; shift = sh; act_en = act;
    in_valid = 1'b1;
    ok = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (last) begin
      raw   = wrap32(m_acc + cyc_sum(px, wt, mode) + longint'(b));
      m_acc = 0;
      e.raw = use_exp ? er : raw;
      e.q   = use_exp ? eq : model_q(raw, int'(sh), act);
      e.cyc = cyc;
      e.lat = lat;
      sbq.push_back(e);
    end else begin
      m_acc += cyc_sum(px, wt, mode);
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_acc = 0;
    sbq.delete();
  endtask

  task automatic drain();
    for (int k = 0; k < 500; k++) begin
      if (sbq.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_left", sbq.size(), 0);
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic rand_data(output pix_t px, output wgt_t wt);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        for (int j = 0; j < 8; j++)
          px[r][c][j*8 +: 8] = 8'($urandom);
    for (int k = 0; k < 72; k++)
      wt[k*8 +: 8] = 8'($urandom);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_out", out_valid, 0);
        end else begin
          chk("out_raw", out_raw, sbq[0].raw);
          chk("out_q", out_q, sbq[0].q);
          if (out_ready) begin
            if (sbq[0].lat) chk("latency", cyc - sbq[0].cyc, 5);
            void'(sbq.pop_front());
          end else begin
            chk("in_ready_stall", in_ready, 0);
            n_stall++;
          end
        end
      end else begin
        chk("in_ready_idle", in_ready, 1);
      end
    end
  end

  initial begin
    pix_t px, px1, px255;
    wgt_t wt, wt1, wtm1;
    int   nb;
    int   gap;
    logic signed [31:0] b;
    logic [4:0] sh;
    bit   act;
    bit   md;

    rst = 1'b1; in_valid = 1'b0; last_channel = 1'b0;
    mode_1x1 = 1'b0; bias = '0; shift = '0; act_en = 1'b0;
    pixels = '0; weights = '0; out_ready = 1'b1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        px1[r][c]   = {8{8'h01}};
        px255[r][c] = {8{8'hFF}};
      end
    wt1  = {72{8'h01}};
    wtm1 = {72{8'hFF}};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_raw", out_raw, 0);
    chk("rst_out_q", out_q, 0);
    chk("rst_in_ready_after", in_ready, 1);
    @(posedge clk); #1;

    send(px1, wt1, 1, 0, 0, 0, 0, 1, 72, 72, 1);
    drain();

    send(px1, wt1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    send(px1, wt1, 1, 0, 0, 1, 0, 1, 144, 72, 1);
    send(px1, wt1, 1, 0, 0, 0, 0, 1, 72, 72, 0);
    drain();

    send(px1, wt1, 1, 1, 10, 0, 0, 1, 18, 18, 1);
    drain();

`ifdef CONV_PE_LEAKY_EN
    send(px255, wtm1, 1, 0, 0, 4, 1, 1, -18360, -117, 1);
`else
    send(px255, wtm1, 1, 0, 0, 4, 1, 1, -18360, -128, 1);
`endif
    drain();

    n_stall = 0;
    fork
      begin
        for (int g = 0; g < 4; g++) begin
          rand_data(px, wt);
          send(px, wt, 1, g[0], 32'($urandom_range(0, 2000)) - 1000,
               5'($urandom_range(0, 12)), 0, 0, 0, 0, 0);
        end
      end
      begin
        for (int k = 0; k < 100; k++) begin
          @(negedge clk);
          if (out_valid) break;
        end
        rdy_force = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rdy_force = 1'b1;
      end
    join
    drain();
    chk("stall_cycles", n_stall, 3);

    send(px1, wt1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    send(px1, wt1, 1, 0, 0, 0, 0, 1, 72, 72, 1);
    drain();

    rdy_rand = 1;
    for (int g = 0; g < 60; g++) begin
      nb = $urandom_range(1, 4);
      for (int k = 0; k < nb; k++) begin
        rand_data(px, wt);
        md  = 1'($urandom);
        b   = ($urandom % 2 == 1) ? 32'($urandom)
                                  : 32'($urandom_range(0, 4000)) - 2000;
        sh  = 5'($urandom_range(0, 20));
        act = 1'($urandom);
        gap = $urandom_range(0, 2);
        repeat (gap) begin @(posedge clk); #1; end
        send(px, wt, k == nb - 1, md, b, sh, act, 0, 0, 0, 0);
      end
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
